// File: rtl/dm_access_ctrl_if.sv
// Request-side handshake between the SISC control path and the data memory
// access controller. The requester holds the master view, the controller the
// slave view.
interface dm_access_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data memory access sequencer. Turns single-cycle load/store requests into
// memory accesses with a one-cycle write strobe (committed on its falling
// edge) and a programmable read wait, and rejects out-of-range addresses.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 65533,
    parameter int unsigned RD_WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_f,
    dm_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] dm_read_addr,
    output logic [ADDR_W-1:0] dm_write_addr,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_read_data
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_WAIT  = 2'd1,
        S_WR_PULSE = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_W would still compare correctly.
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(RD_WAIT - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       addr_ok;

    // Range check of the incoming request address.
    always_comb begin
        addr_ok = ({1'b0, bus.req_addr} < DEPTH_L);
    end

    // Sequencer: all outputs registered. On reset dm_we drops immediately,
    // which is itself the falling edge that commits a store caught in
    // WR_PULSE; that is intended and must stay that way.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            dm_read_addr  <= '0;
            dm_write_addr <= '0;
            dm_write_data <= '0;
            dm_we         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        bus.busy <= 1'b1;
                        if (!addr_ok) begin
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else if (bus.req_we) begin
                            dm_write_addr <= bus.req_addr;
                            dm_write_data <= bus.req_wdata;
                            dm_we         <= 1'b1;
                            state         <= S_WR_PULSE;
                        end else begin
                            dm_read_addr <= bus.req_addr;
                            wait_cnt     <= WAIT_INIT;
                            state        <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        bus.rdata <= dm_read_data;
                        bus.done  <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_WR_PULSE: begin
                    // Address/data stay put until the next accepted store,
                    // giving hold across this falling edge.
                    dm_we    <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a RD_WAIT=1 instance with a full-size
// falling-edge-write memory model, and a RD_WAIT=3 instance with a small
// read-only memory.
module tb_dm_access_ctrl;

    logic clk;
    logic rst_f;
    int   checks;
    int   errors;
    int   done_cnt;
    int   we_rise;

    // Instance A: RD_WAIT = 1
    dm_access_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bi ();
    logic [15:0] ra, wa;
    logic [31:0] wd, rd;
    logic        we;
    logic [31:0] mem [0:65535];
    logic [15:0] sh_a;
    logic [31:0] sh_d;

    dm_access_ctrl #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(65533), .RD_WAIT(1)) u_dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .bus           (bi.slave),
        .dm_read_addr  (ra),
        .dm_write_addr (wa),
        .dm_write_data (wd),
        .dm_we         (we),
        .dm_read_data  (rd)
    );

    // Instance B: RD_WAIT = 3
    dm_access_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bi3 ();
    logic [15:0] ra3, wa3;
    logic [31:0] wd3;
    logic        we3;
    logic [31:0] mem3 [0:15];

    dm_access_ctrl #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(65533), .RD_WAIT(3)) u_dut3 (
        .clk           (clk),
        .rst_f         (rst_f),
        .bus           (bi3.slave),
        .dm_read_addr  (ra3),
        .dm_write_addr (wa3),
        .dm_write_data (wd3),
        .dm_we         (we3),
        .dm_read_data  (mem3[ra3[3:0]])
    );

    // Memory model: asynchronous read; address/data sampled while the strobe
    // is high, write committed on the strobe's falling edge.
    assign rd = mem[ra];

    always @(negedge clk) begin
        if (we) begin
            sh_a = wa;
            sh_d = wd;
        end
    end

    always @(negedge we) mem[sh_a] = sh_d;
    always @(posedge we) we_rise++;
    always @(posedge clk) if (bi.done) done_cnt++;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int          d0;
    int          w0;
    logic [31:0] r0;

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        we_rise  = 0;
        rst_f    = 1'b1;
        bi.req = 1'b0;  bi.req_we = 1'b0;  bi.req_addr = '0;  bi.req_wdata = '0;
        bi3.req = 1'b0; bi3.req_we = 1'b0; bi3.req_addr = '0; bi3.req_wdata = '0;
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 32'hA5000000 | i;
        for (int unsigned i = 0; i < 16; i++) mem3[i] = 32'h0C0FFEE0 | i;

        // 1. asynchronous reset between clock edges
        #2 rst_f = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bi.busy}, 32'd0);
        chk("rst_done", {31'd0, bi.done}, 32'd0);
        chk("rst_err", {31'd0, bi.err}, 32'd0);
        chk("rst_rdata", bi.rdata, 32'd0);
        chk("rst_ra", {16'd0, ra}, 32'd0);
        chk("rst_wa", {16'd0, wa}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        cyc(); rst_f = 1'b1;
        cyc(); cyc(); cyc();
        chk("idle_busy", {31'd0, bi.busy}, 32'd0);
        chk("idle_we", {31'd0, we}, 32'd0);

        // 2. store 0x0005 <- DEADBEEF, then load it back
        bi.req = 1'b1; bi.req_we = 1'b1; bi.req_addr = 16'h0005; bi.req_wdata = 32'hDEADBEEF;
        cyc();
        bi.req = 1'b0;
        chk("st_we_hi", {31'd0, we}, 32'd1);
        chk("st_wa", {16'd0, wa}, 32'h0005);
        chk("st_wd", wd, 32'hDEADBEEF);
        chk("st_busy", {31'd0, bi.busy}, 32'd1);
        chk("st_nodone", {31'd0, bi.done}, 32'd0);
        cyc();
        chk("st_we_lo", {31'd0, we}, 32'd0);
        chk("st_done", {31'd0, bi.done}, 32'd1);
        chk("st_err", {31'd0, bi.err}, 32'd0);
        chk("st_wa_hold", {16'd0, wa}, 32'h0005);
        chk("st_wd_hold", wd, 32'hDEADBEEF);
        chk("st_mem", mem[16'h0005], 32'hDEADBEEF);
        cyc();
        chk("st_idle", {31'd0, bi.busy}, 32'd0);
        chk("st_done_1cyc", {31'd0, bi.done}, 32'd0);

        w0 = we_rise;
        bi.req = 1'b1; bi.req_we = 1'b0; bi.req_addr = 16'h0005;
        cyc();
        bi.req = 1'b0;
        chk("ld_ra", {16'd0, ra}, 32'h0005);
        chk("ld_busy", {31'd0, bi.busy}, 32'd1);
        chk("ld_nodone", {31'd0, bi.done}, 32'd0);
        cyc();
        chk("ld_done", {31'd0, bi.done}, 32'd1);
        chk("ld_err", {31'd0, bi.err}, 32'd0);
        chk("ld_rdata", bi.rdata, 32'hDEADBEEF);
        chk("ld_wa_kept", {16'd0, wa}, 32'h0005);
        cyc();
        chk("ld_idle", {31'd0, bi.busy}, 32'd0);
        chk("ld_no_we", we_rise, w0);

        // 3. RD_WAIT=3 load of 0x0002
        bi3.req = 1'b1; bi3.req_we = 1'b0; bi3.req_addr = 16'h0002;
        cyc();
        bi3.req = 1'b0;
        chk("w3_busy1", {31'd0, bi3.busy}, 32'd1);
        chk("w3_ra", {16'd0, ra3}, 32'h0002);
        chk("w3_nodone1", {31'd0, bi3.done}, 32'd0);
        cyc();
        chk("w3_busy2", {31'd0, bi3.busy}, 32'd1);
        chk("w3_nodone2", {31'd0, bi3.done}, 32'd0);
        cyc();
        chk("w3_busy3", {31'd0, bi3.busy}, 32'd1);
        chk("w3_nodone3", {31'd0, bi3.done}, 32'd0);
        chk("w3_ra_hold", {16'd0, ra3}, 32'h0002);
        cyc();
        chk("w3_busy4", {31'd0, bi3.busy}, 32'd1);
        chk("w3_done", {31'd0, bi3.done}, 32'd1);
        chk("w3_rdata", bi3.rdata, 32'h0C0FFEE2);
        cyc();
        chk("w3_idle", {31'd0, bi3.busy}, 32'd0);
        chk("w3_done_off", {31'd0, bi3.done}, 32'd0);

        // 4. out-of-range store, then highest valid load
        w0 = we_rise;
        bi.req = 1'b1; bi.req_we = 1'b1; bi.req_addr = 16'hFFFD; bi.req_wdata = 32'h11111111;
        cyc();
        bi.req = 1'b0;
        chk("oor_done", {31'd0, bi.done}, 32'd1);
        chk("oor_err", {31'd0, bi.err}, 32'd1);
        chk("oor_busy", {31'd0, bi.busy}, 32'd1);
        chk("oor_we", {31'd0, we}, 32'd0);
        chk("oor_wa", {16'd0, wa}, 32'h0005);
        chk("oor_wd", wd, 32'hDEADBEEF);
        chk("oor_rdata", bi.rdata, 32'hDEADBEEF);
        cyc();
        chk("oor_done_off", {31'd0, bi.done}, 32'd0);
        chk("oor_err_off", {31'd0, bi.err}, 32'd0);
        chk("oor_idle", {31'd0, bi.busy}, 32'd0);
        chk("oor_no_we", we_rise, w0);

        bi.req = 1'b1; bi.req_we = 1'b0; bi.req_addr = 16'hFFFC;
        cyc();
        bi.req = 1'b0;
        chk("max_ra", {16'd0, ra}, 32'h0000FFFC);
        cyc();
        chk("max_done", {31'd0, bi.done}, 32'd1);
        chk("max_err", {31'd0, bi.err}, 32'd0);
        chk("max_rdata", bi.rdata, 32'hA500FFFC);
        cyc();

        // 5. request while busy is ignored; store then load in first IDLE
        d0 = done_cnt;
        w0 = we_rise;
        bi.req = 1'b1; bi.req_we = 1'b1; bi.req_addr = 16'h0020; bi.req_wdata = 32'hCAFEF00D;
        cyc();
        bi.req_addr = 16'h0021; bi.req_wdata = 32'h0BADBAD0;
        cyc();
        bi.req = 1'b0;
        chk("b2b_st_done", {31'd0, bi.done}, 32'd1);
        cyc();
        chk("b2b_idle", {31'd0, bi.busy}, 32'd0);
        bi.req = 1'b1; bi.req_we = 1'b0; bi.req_addr = 16'h0020;
        cyc();
        bi.req = 1'b0;
        cyc();
        chk("b2b_ld_done", {31'd0, bi.done}, 32'd1);
        chk("b2b_rdata", bi.rdata, 32'hCAFEF00D);
        cyc();
        chk("b2b_done_cnt", done_cnt - d0, 32'd2);
        chk("b2b_we_cnt", we_rise - w0, 32'd1);
        chk("b2b_ignored_mem", mem[16'h0021], 32'hA5000021);
        chk("b2b_wa", {16'd0, wa}, 32'h0020);

        // 6. reset during WR_PULSE still commits the store
        bi.req = 1'b1; bi.req_we = 1'b1; bi.req_addr = 16'h000A; bi.req_wdata = 32'h12345678;
        cyc();
        bi.req = 1'b0;
        chk("rw_we_hi", {31'd0, we}, 32'd1);
        d0 = done_cnt;
        #1 rst_f = 1'b0;
        #1;
        chk("rw_we_lo", {31'd0, we}, 32'd0);
        chk("rw_mem", mem[16'h000A], 32'h12345678);
        chk("rw_busy", {31'd0, bi.busy}, 32'd0);
        chk("rw_done", {31'd0, bi.done}, 32'd0);
        chk("rw_rdata", bi.rdata, 32'd0);
        chk("rw_rdata3", bi3.rdata, 32'd0);
        cyc(); rst_f = 1'b1;
        cyc(); cyc(); cyc();
        chk("rw_no_done", done_cnt - d0, 32'd0);
        chk("rw_idle", {31'd0, bi.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequencing controller directly upstream of the data memory. Drives its read_addr, write_addr, write_data and dm_we, and captures read_data.
- Converts single-cycle load/store requests from the SISC control path into correctly timed memory accesses.
- The memory commits writes on the falling edge of dm_we and reads asynchronously from its address inputs. This block guarantees address/data setup before, and hold across, that falling edge.
- Also rejects addresses beyond the memory depth.

Parameters:
- ADDR_W, 16, address width on both the request side and the memory side.
- DATA_W, 32, data word width.
- MEM_DEPTH, 65533, number of implemented words; valid addresses are 0..MEM_DEPTH-1.
- RD_WAIT, 1, cycles between driving the read address and capturing read data; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_f  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- req_we  input  1  1 = store, 0 = load; sampled with req.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = address out of range, no access made.
- rdata  output  DATA_W  load result; holds until the next successful load.
- dm_read_addr  output  ADDR_W  to memory read_addr.
- dm_write_addr  output  ADDR_W  to memory write_addr.
- dm_write_data  output  DATA_W  to memory write_data.
- dm_we  output  1  to memory dm_we; the write commits on its falling edge.
- dm_read_data  input  DATA_W  from memory read_data.

Behaviour:
- **Reset:** asynchronous, rst_f low. All outputs go to 0 (busy, done, err, rdata, dm_read_addr, dm_write_addr, dm_write_data, dm_we) and the state goes to IDLE. Reset is independent of clk.
- **States:** IDLE, RD_WAIT, WR_PULSE, DONE. All outputs are registered; busy = (state != IDLE).
- **IDLE, req=1, req_addr >= MEM_DEPTH:**
  - Go to DONE with err=1.
  - No dm_* output changes; dm_we stays 0; rdata is unchanged.
- **IDLE, req=1, req_we=0, address in range (load):**
  - dm_read_addr <= req_addr.
  - Wait counter <= RD_WAIT-1; go to RD_WAIT.
- **RD_WAIT:**
  - While the counter is non-zero, decrement it.
  - At zero: rdata <= dm_read_data, err <= 0, go to DONE.
  - dm_read_addr is held for the whole access.
- **IDLE, req=1, req_we=1, address in range (store):**
  - dm_write_addr <= req_addr, dm_write_data <= req_wdata, dm_we <= 1.
  - Go to WR_PULSE.
- **WR_PULSE:**
  - dm_we <= 0; the falling edge commits the write. err <= 0; go to DONE.
  - dm_write_addr and dm_write_data are not changed until the next accepted store, so hold across the falling edge is guaranteed.
- **DONE:** done is high for exactly this one cycle; go to IDLE. done and err are 0 in all other states.
- **Latency, with E0 = the edge sampling req:**
  - Load: done is high in the cycle after edge E0+1+RD_WAIT−1, i.e. after E1 when RD_WAIT=1.
  - Store: done is high after E1.
  - Out-of-range: done is high after E0.
  - Minimum issue interval is 3 cycles for a store and 2+RD_WAIT for a load.
- **req outside IDLE:** ignored; not queued, no error. The requester must wait for busy=0.
- **req in the IDLE cycle that follows DONE:** accepted normally, so back-to-back operations have no bubble beyond DONE.
- **dm_read_addr during a store:** unchanged. dm_write_* during a load: unchanged.
- **Reset while in WR_PULSE:**
  - The forced dm_we 1→0 transition is a falling edge, so the store commits using the pre-reset address and data.
  - No done is issued.
  - This behaviour is required and must not be masked.
- **Reset while in RD_WAIT:** the load is abandoned; rdata = 0.
- **Address boundary:** address MEM_DEPTH-1 (65532) is valid; 65533..65535 produce err.

Test Plan:
1. Reset with rst_f=0 mid-cycle (no clk edge) → all outputs 0 immediately. Release rst_f, idle 3 cycles → busy=0, dm_we=0.
2. Store addr=0x0005, data=0xDEADBEEF:
   - dm_we=1 for exactly one cycle with dm_write_addr=0x0005 and dm_write_data=0xDEADBEEF stable from before the rise until after the fall.
   - done after E1, err=0.
   - Then load 0x0005 → rdata=0xDEADBEEF, done after E1.
3. Load at RD_WAIT=3, addr=0x0002 → done exactly 3 edges after the request edge. rdata equals the memory word. busy=1 for 4 cycles.
4. Request addr=0xFFFD (store) → done+err after E0, dm_we never rises, rdata unchanged. Addr=0xFFFC load → err=0, valid data.
5. Issue a second req while busy=1 → ignored (no extra done, no dm_we). Issue back-to-back store then load in the first IDLE after DONE → both complete; load returns the stored value.
6. Assert rst_f=0 during WR_PULSE with addr=0x000A, data=0x12345678 → dm_we falls, memory word 0x000A=0x12345678, no done pulse, state IDLE after release.
